// File: rtl/cpu_pkg.sv
// Shared CPU constants: next-PC opcodes and the default memory map used by
// the PC unit, CP0 and the instruction-memory model.
package cpu_pkg;

    localparam logic [3:0] NPC_SEQ  = 4'd0;
    localparam logic [3:0] NPC_BEQ  = 4'd1;
    localparam logic [3:0] NPC_J    = 4'd2;
    localparam logic [3:0] NPC_JR   = 4'd3;
    localparam logic [3:0] NPC_BNE  = 4'd4;
    localparam logic [3:0] NPC_BMSB = 4'd5;
    localparam logic [3:0] NPC_BGEZ = 4'd6;
    localparam logic [3:0] NPC_BLTZ = 4'd7;

    localparam logic [31:0] RESET_VEC_DEFAULT  = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEFAULT    = 32'h0000_4180;
    localparam logic [31:0] IMEM_BASE_DEFAULT  = 32'h0000_3000;
    localparam logic [31:0] IMEM_LIMIT_DEFAULT = 32'h0000_6FFC;

endpackage

// File: rtl/msb_index.sv
// 32-bit priority encoder: index of the most-significant set bit plus a
// nonzero flag (index is 0 when the input is zero).
module msb_index (
    input  logic [31:0] value,
    output logic [4:0]  index,
    output logic        nonzero
);

    always_comb begin
        index = 5'd0;
        // Ascending scan, so the highest set bit is the last assignment.
        for (int i = 0; i < 32; i++) begin
            if (value[i]) begin
                index = 5'(i);
            end
        end
    end

    assign nonzero = |value;

endmodule

// File: rtl/pc_unit_ex.sv
// Fetch-stage program counter: resolves next PC from D-stage branch/jump
// operands, with exception redirect, eret via EPC and fetch address checks.
module pc_unit_ex
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter logic [31:0] RESET_VEC  = RESET_VEC_DEFAULT,
    parameter logic [31:0] EXC_VEC    = EXC_VEC_DEFAULT,
    parameter logic [31:0] IMEM_BASE  = IMEM_BASE_DEFAULT,
    parameter logic [31:0] IMEM_LIMIT = IMEM_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              imem_ready,
    input  logic [3:0]        next_pc_op,
    input  logic [31:0]       rs_data,
    input  logic [31:0]       rt_data,
    input  logic [15:0]       imm16,
    input  logic [25:0]       j_index,
    input  logic              exc_req,
    input  logic              eret_req,
    input  logic [ADDR_W-1:0] epc,
    output logic [ADDR_W-1:0] pc_out,
    output logic              branch_taken,
    output logic              fetch_adel
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus4, br_target, j_target;
    logic [31:0]       pc_ext, j_full;
    logic [4:0]        rs_msb, rt_msb;
    logic              rs_nz, rt_nz;
    logic              cond, is_branch, redirect_block;

    msb_index u_msb_rs (
        .value   (rs_data),
        .index   (rs_msb),
        .nonzero (rs_nz)
    );

    msb_index u_msb_rt (
        .value   (rt_data),
        .index   (rt_msb),
        .nonzero (rt_nz)
    );

    // Zero-extend so the region bits and range checks work for any ADDR_W.
    assign pc_ext    = 32'(pc_q);
    assign pc_plus4  = pc_q + ADDR_W'(4);
    assign br_target = pc_q + {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
    assign j_full    = {pc_ext[31:28], j_index, 2'b00};
    assign j_target  = j_full[ADDR_W-1:0];

    always_comb begin
        cond      = 1'b0;
        is_branch = 1'b0;
        case (next_pc_op)
            NPC_BEQ: begin
                is_branch = 1'b1;
                cond      = (rs_data == rt_data);
            end
            NPC_BNE: begin
                is_branch = 1'b1;
                cond      = (rs_data != rt_data);
            end
            NPC_BMSB: begin
                is_branch = 1'b1;
                cond      = rs_nz & rt_nz & (rs_msb == rt_msb);
            end
            NPC_BGEZ: begin
                is_branch = 1'b1;
                cond      = ~rs_data[31];
            end
            NPC_BLTZ: begin
                is_branch = 1'b1;
                cond      = rs_data[31];
            end
            default: begin
                is_branch = 1'b0;
                cond      = 1'b0;
            end
        endcase
    end

    assign redirect_block = reset | exc_req | eret_req | stall;
    assign branch_taken   = is_branch & cond & ~redirect_block;

    always_comb begin
        pc_d = pc_q;
        if (reset) begin
            pc_d = RESET_VEC[ADDR_W-1:0];
        end else if (exc_req) begin
            pc_d = EXC_VEC[ADDR_W-1:0];
        end else if (eret_req) begin
            pc_d = epc;
        end else if (stall || !imem_ready) begin
            pc_d = pc_q;
        end else begin
            case (next_pc_op)
                NPC_J:    pc_d = j_target;
                NPC_JR:   pc_d = rs_data[ADDR_W-1:0];
                NPC_BEQ, NPC_BNE, NPC_BMSB, NPC_BGEZ, NPC_BLTZ:
                          pc_d = cond ? br_target : pc_plus4;
                default:  pc_d = pc_plus4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

    assign pc_out     = pc_q;
    assign fetch_adel = (pc_q[1:0] != 2'b00) | (pc_ext < IMEM_BASE) | (pc_ext > IMEM_LIMIT);

endmodule

// File: tb/tb_pc_unit_ex.sv
// Directed-vector bench for pc_unit_ex: table of per-edge steps plus a few
// hand-written multi-cycle sequences.
module tb_pc_unit_ex;

    logic        clk = 1'b0;
    logic        reset, stall, imem_ready, exc_req, eret_req;
    logic [3:0]  next_pc_op;
    logic [31:0] rs_data, rt_data, epc, pc_out;
    logic [15:0] imm16;
    logic [25:0] j_index;
    logic        branch_taken, fetch_adel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_unit_ex dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .imem_ready   (imem_ready),
        .next_pc_op   (next_pc_op),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .imm16        (imm16),
        .j_index      (j_index),
        .exc_req      (exc_req),
        .eret_req     (eret_req),
        .epc          (epc),
        .pc_out       (pc_out),
        .branch_taken (branch_taken),
        .fetch_adel   (fetch_adel)
    );

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rdy;
        logic        exc;
        logic        ert;
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [25:0] jidx;
        logic [31:0] epcv;
        logic        bt;
        logic [31:0] pc;
        logic        adel;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset      = v.rst;
        stall      = v.stl;
        imem_ready = v.rdy;
        exc_req    = v.exc;
        eret_req   = v.ert;
        next_pc_op = v.op;
        rs_data    = v.rs;
        rt_data    = v.rt;
        imm16      = v.imm;
        j_index    = v.jidx;
        epc        = v.epcv;
    endtask

    // One edge: drive at negedge, check combinational branch_taken, then
    // check the registered PC and fetch_adel just after the rising edge.
    task automatic step(input vec_t v, input int idx);
        @(negedge clk);
        drive(v);
        #1;
        chk("branch_taken", idx, 32'(branch_taken), 32'(v.bt));
        @(posedge clk);
        #1;
        chk("pc_out", idx, pc_out, v.pc);
        chk("fetch_adel", idx, 32'(fetch_adel), 32'(v.adel));
    endtask

    task automatic add(input logic rst, input logic stl, input logic rdy, input logic exc,
                       input logic ert, input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] imm, input logic [25:0] jidx,
                       input logic [31:0] epcv, input logic bt, input logic [31:0] pc,
                       input logic adel);
        vec_t v;
        v = '{rst, stl, rdy, exc, ert, op, rs, rt, imm, jidx, epcv, bt, pc, adel};
        vecs.push_back(v);
    endtask

    initial begin
        vec_t v;
        drive('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 16'd0, 26'd0, 32'd0,
                1'b0, 32'd0, 1'b0});

        //  rst stl rdy exc ert op  rs            rt          imm      jidx      epc   bt pc          adel
        add(1, 0, 1, 0, 0, 4'd0, 32'd0,        32'd0,      16'h0,    26'h0,    32'h0, 0, 32'h3000, 0);
        add(0, 0, 1, 0, 0, 4'd0, 32'd0,        32'd0,      16'h0,    26'h0,    32'h0, 0, 32'h3004, 0);
        add(0, 0, 1, 0, 0, 4'd0, 32'd0,        32'd0,      16'h0,    26'h0,    32'h0, 0, 32'h3008, 0);
        add(0, 0, 1, 0, 0, 4'd0, 32'd0,        32'd0,      16'h0,    26'h0,    32'h0, 0, 32'h300C, 0);
        add(0, 0, 1, 0, 0, 4'd0, 32'd0,        32'd0,      16'h0,    26'h0,    32'h0, 0, 32'h3010, 0);
        add(0, 0, 1, 0, 0, 4'd1, 32'd5,        32'd5,      16'hFFFE, 26'h0,    32'h0, 1, 32'h3008, 0);
        add(0, 0, 1, 0, 0, 4'd0, 32'd0,        32'd0,      16'h0,    26'h0,    32'h0, 0, 32'h300C, 0);
        add(0, 0, 1, 0, 0, 4'd0, 32'd0,        32'd0,      16'h0,    26'h0,    32'h0, 0, 32'h3010, 0);
        add(0, 0, 1, 0, 0, 4'd1, 32'd5,        32'd6,      16'hFFFE, 26'h0,    32'h0, 0, 32'h3014, 0);
        add(1, 0, 1, 0, 0, 4'd0, 32'd0,        32'd0,      16'h0,    26'h0,    32'h0, 0, 32'h3000, 0);
        add(0, 0, 1, 0, 0, 4'd5, 32'hF0,       32'h81,     16'h4,    26'h0,    32'h0, 1, 32'h3010, 0);
        add(1, 0, 1, 0, 0, 4'd0, 32'd0,        32'd0,      16'h0,    26'h0,    32'h0, 0, 32'h3000, 0);
        add(0, 0, 1, 0, 0, 4'd5, 32'h100,      32'h80,     16'h4,    26'h0,    32'h0, 0, 32'h3004, 0);
        add(1, 0, 1, 0, 0, 4'd0, 32'd0,        32'd0,      16'h0,    26'h0,    32'h0, 0, 32'h3000, 0);
        add(0, 0, 1, 0, 0, 4'd5, 32'h0,        32'h0,      16'h4,    26'h0,    32'h0, 0, 32'h3004, 0);
        add(0, 0, 1, 0, 0, 4'd4, 32'd1,        32'd2,      16'h2,    26'h0,    32'h0, 1, 32'h300C, 0);
        add(0, 0, 1, 0, 0, 4'd6, 32'h8000_0000, 32'd0,     16'h4,    26'h0,    32'h0, 0, 32'h3010, 0);
        add(0, 0, 1, 0, 0, 4'd7, 32'h8000_0000, 32'd0,     16'hFFFC, 26'h0,    32'h0, 1, 32'h3000, 0);
        add(0, 0, 1, 0, 0, 4'd9, 32'd5,        32'd5,      16'h4,    26'h0,    32'h0, 0, 32'h3004, 0);
        add(0, 0, 1, 0, 0, 4'd6, 32'd1,        32'd0,      16'h1,    26'h0,    32'h0, 1, 32'h3008, 0);
        // stall with a taken beq, exception arrives in the second stalled cycle
        add(0, 1, 1, 0, 0, 4'd1, 32'd5,        32'd5,      16'h4,    26'h0,    32'h0, 0, 32'h3008, 0);
        add(0, 1, 1, 1, 0, 4'd1, 32'd5,        32'd5,      16'h4,    26'h0,    32'h0, 0, 32'h4180, 0);
        add(0, 1, 1, 0, 0, 4'd1, 32'd5,        32'd5,      16'h4,    26'h0,    32'h0, 0, 32'h4180, 0);
        add(0, 0, 1, 0, 1, 4'd1, 32'd5,        32'd5,      16'h4,    26'h0, 32'h3024, 0, 32'h3024, 0);
        add(0, 0, 1, 1, 1, 4'd0, 32'd0,        32'd0,      16'h0,    26'h0, 32'h3024, 0, 32'h4180, 0);
        // instruction-memory backpressure on a jump
        add(0, 0, 0, 0, 0, 4'd2, 32'd0,        32'd0,      16'h0,    26'h0C10, 32'h0, 0, 32'h4180, 0);
        add(0, 0, 0, 0, 0, 4'd2, 32'd0,        32'd0,      16'h0,    26'h0C10, 32'h0, 0, 32'h4180, 0);
        add(0, 0, 1, 0, 0, 4'd2, 32'd0,        32'd0,      16'h0,    26'h0C10, 32'h0, 0, 32'h3040, 0);
        // address-error detection
        add(0, 0, 1, 0, 0, 4'd3, 32'h3002,     32'd0,      16'h0,    26'h0,    32'h0, 0, 32'h3002, 1);
        add(1, 0, 1, 0, 0, 4'd0, 32'd0,        32'd0,      16'h0,    26'h0,    32'h0, 0, 32'h3000, 0);
        add(0, 0, 1, 0, 0, 4'd3, 32'h7000,     32'd0,      16'h0,    26'h0,    32'h0, 0, 32'h7000, 1);
        add(1, 0, 1, 0, 0, 4'd0, 32'd0,        32'd0,      16'h0,    26'h0,    32'h0, 0, 32'h3000, 0);
        add(0, 0, 1, 0, 0, 4'd3, 32'h2FFC,     32'd0,      16'h0,    26'h0,    32'h0, 0, 32'h2FFC, 1);
        add(0, 0, 1, 0, 0, 4'd3, 32'h6FFC,     32'd0,      16'h0,    26'h0,    32'h0, 0, 32'h6FFC, 0);
        add(0, 0, 1, 0, 0, 4'd0, 32'd0,        32'd0,      16'h0,    26'h0,    32'h0, 0, 32'h7000, 1);
        add(0, 0, 1, 0, 0, 4'd0, 32'd0,        32'd0,      16'h0,    26'h0,    32'h0, 0, 32'h7004, 1);
        add(0, 0, 1, 0, 0, 4'd3, 32'hFFFF_FFFC, 32'd0,     16'h0,    26'h0,    32'h0, 0, 32'hFFFF_FFFC, 1);
        add(0, 0, 1, 0, 0, 4'd0, 32'd0,        32'd0,      16'h0,    26'h0,    32'h0, 0, 32'h0, 1);
        // branch_taken is not gated by imem_ready, but the PC holds
        add(1, 0, 1, 0, 0, 4'd0, 32'd0,        32'd0,      16'h0,    26'h0,    32'h0, 0, 32'h3000, 0);
        add(0, 0, 0, 0, 0, 4'd1, 32'd9,        32'd9,      16'h4,    26'h0,    32'h0, 1, 32'h3000, 0);
        add(0, 0, 1, 0, 0, 4'd1, 32'd9,        32'd9,      16'h4,    26'h0,    32'h0, 1, 32'h3010, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end

        // Long stall: PC must stay put for every stalled cycle, then resume.
        v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 16'd0, 26'd0, 32'd0,
              1'b0, 32'h3000, 1'b0};
        step(v, 100);
        v.rst = 1'b0;
        v.stl = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(v, 101 + i);
        end
        v.stl = 1'b0;
        v.pc  = 32'h3004;
        step(v, 106);

        // Reset beats a simultaneous exception and eret.
        v.rst = 1'b1;
        v.exc = 1'b1;
        v.ert = 1'b1;
        v.epcv = 32'h3024;
        v.pc  = 32'h3000;
        step(v, 107);

        // Exception beats stall and backpressure together.
        v.rst = 1'b0;
        v.ert = 1'b0;
        v.stl = 1'b1;
        v.rdy = 1'b0;
        v.pc  = 32'h4180;
        step(v, 108);

        // eret also overrides stall.
        v.exc = 1'b0;
        v.ert = 1'b1;
        v.epcv = 32'h3100;
        v.pc  = 32'h3100;
        step(v, 109);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
